// File: rtl/cache_axi_rd_arbiter_if.sv
// Bundle of the two cache read ports and the AXI read address/data channels.
// master = the arbiter, slave = the caches and AXI fabric around it.
interface cache_axi_rd_arbiter_if;
  logic        icache_rd_req;
  logic        icache_rd_type;
  logic [31:0] icache_rd_addr;
  logic        icache_rd_rdy;
  logic        icache_ret_valid;
  logic        icache_ret_last;
  logic [31:0] icache_ret_data;

  logic        dcache_rd_req;
  logic        dcache_rd_type;
  logic [31:0] dcache_rd_addr;
  logic        dcache_rd_rdy;
  logic        dcache_ret_valid;
  logic        dcache_ret_last;
  logic [31:0] dcache_ret_data;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  icache_rd_req, icache_rd_type, icache_rd_addr,
    output icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    input  dcache_rd_req, dcache_rd_type, dcache_rd_addr,
    output dcache_rd_rdy, dcache_ret_valid, dcache_ret_last, dcache_ret_data,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output icache_rd_req, icache_rd_type, icache_rd_addr,
    input  icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    output dcache_rd_req, dcache_rd_type, dcache_rd_addr,
    input  dcache_rd_rdy, dcache_ret_valid, dcache_ret_last, dcache_ret_data,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cache_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between icache and dcache,
// with a single outstanding read and zero-latency pass-through of R beats.
module cache_axi_rd_arbiter #(
  parameter int unsigned LINE_BEATS = 4,
  parameter logic [3:0]  ICACHE_ID  = 4'd0,
  parameter logic [3:0]  DCACHE_ID  = 4'd1
) (
  input  logic                          clk,
  input  logic                          reset,
  cache_axi_rd_arbiter_if.master        bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last_grant;   // 0 = icache, 1 = dcache
  logic        r_owner;        // 0 = icache, 1 = dcache
  logic        r_type;
  logic [31:0] r_addr;
  logic [1:0]  r_cnt;

  logic        w_gnt_i;
  logic        w_gnt_d;
  logic        w_accept;
  logic        w_beat;
  logic        w_done;
  logic [7:0]  w_len;
  logic [3:0]  w_id;
  logic        w_err;
  logic        w_unused;

  // On a tie the requester that was not served last wins.
  assign w_gnt_i  = bus.icache_rd_req & (~bus.dcache_rd_req | r_last_grant);
  assign w_gnt_d  = bus.dcache_rd_req & (~bus.icache_rd_req | ~r_last_grant);
  assign w_accept = (r_state == IDLE) & (w_gnt_i | w_gnt_d);
  assign w_beat   = (r_state == DATA) & bus.rvalid;
  assign w_done   = w_beat & bus.rlast;
  assign w_len    = r_type ? LINE_LEN : 8'd0;
  assign w_id     = r_owner ? DCACHE_ID : ICACHE_ID;

  // Protocol anomalies are tolerated: the beat is forwarded and rlast still ends the burst.
  assign w_err    = w_done & ((r_cnt != w_len[1:0]) | (bus.rid != w_id));
  assign w_unused = ^{w_err, bus.rresp};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)    w_next = ADDR;
      ADDR:    if (bus.arready) w_next = DATA;
      DATA:    if (w_done)      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b0;
      r_owner      <= 1'b0;
      r_type       <= 1'b0;
      r_addr       <= 32'd0;
      r_cnt        <= 2'd0;
    end else if (w_accept) begin
      r_last_grant <= w_gnt_d;
      r_owner      <= w_gnt_d;
      r_type       <= w_gnt_d ? bus.dcache_rd_type : bus.icache_rd_type;
      r_addr       <= w_gnt_d ? bus.dcache_rd_addr : bus.icache_rd_addr;
      r_cnt        <= 2'd0;
    end else if (w_beat) begin
      r_cnt        <= r_cnt + 2'd1;
    end
  end

  always_comb begin
    bus.icache_rd_rdy    = 1'b0;
    bus.dcache_rd_rdy    = 1'b0;
    bus.arvalid          = 1'b0;
    bus.arid             = 4'd0;
    bus.araddr           = 32'd0;
    bus.arlen            = 8'd0;
    bus.rready           = 1'b0;
    bus.icache_ret_valid = 1'b0;
    bus.icache_ret_last  = 1'b0;
    bus.dcache_ret_valid = 1'b0;
    bus.dcache_ret_last  = 1'b0;
    case (r_state)
      IDLE: begin
        bus.icache_rd_rdy = w_gnt_i;
        bus.dcache_rd_rdy = w_gnt_d;
      end
      ADDR: begin
        bus.arvalid = 1'b1;
        bus.arid    = w_id;
        bus.araddr  = r_type ? {r_addr[31:4], 4'b0000} : r_addr;
        bus.arlen   = w_len;
      end
      DATA: begin
        bus.rready           = 1'b1;
        bus.icache_ret_valid = bus.rvalid & ~r_owner;
        bus.icache_ret_last  = bus.rvalid & ~r_owner & bus.rlast;
        bus.dcache_ret_valid = bus.rvalid & r_owner;
        bus.dcache_ret_last  = bus.rvalid & r_owner & bus.rlast;
      end
      default: ;
    endcase
  end

  assign bus.arsize          = 3'b010;
  assign bus.arburst         = 2'b01;
  assign bus.icache_ret_data = bus.rdata;
  assign bus.dcache_ret_data = bus.rdata;
endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for cache_axi_rd_arbiter: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_cache_axi_rd_arbiter;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic reset;
  cache_axi_rd_arbiter_if bus();

  cache_axi_rd_arbiter #(.LINE_BEATS(LB), .ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ar_prob = 100, rv_prob = 100, stray_en = 0, early_en = 0;
  logic [43:0] ar_log[$];   // {arid, araddr, arlen} per address handshake
  logic [33:0] ret_log[$];  // {owner(1=dcache), last, data} per returned word

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_rets(input int n, input int budget);
    int k = 0;
    while (ret_log.size() < n && k < budget) begin tick(1); k++; end
    chk("ret_count", ret_log.size(), n);
  endtask

  task automatic wait_ars(input int n, input int budget);
    int k = 0;
    while (ar_log.size() < n && k < budget) begin tick(1); k++; end
    chk("ar_count", ar_log.size(), n);
  endtask

  // Reference model: who owns the port, whether its address is still pending.
  int          m_owner = -1;
  bit          m_arp = 0, m_line = 0, m_last = 0;
  logic [31:0] m_addr = 0;
  int          outstanding = 0;

  always @(negedge clk) begin
    bit idle, e_arv, e_rr, e_rvi, e_rvd;
    int win;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [3:0]  e_id;
    if (reset) begin
      m_owner = -1; m_arp = 0; m_line = 0; m_addr = 0; m_last = 0; outstanding = 0;
    end
    idle = (m_owner < 0);
    win  = -1;
    if (idle) begin
      if (bus.icache_rd_req && bus.dcache_rd_req) win = m_last ? 0 : 1;
      else if (bus.icache_rd_req) win = 0;
      else if (bus.dcache_rd_req) win = 1;
    end
    e_arv  = !idle && m_arp;
    e_rr   = !idle && !m_arp;
    e_id   = (e_arv && m_owner == 1) ? 4'd1 : 4'd0;
    e_addr = e_arv ? (m_line ? (m_addr / 16) * 16 : m_addr) : 32'd0;
    e_len  = (e_arv && m_line) ? 8'(LB - 1) : 8'd0;
    e_rvi  = e_rr && bus.rvalid && m_owner == 0;
    e_rvd  = e_rr && bus.rvalid && m_owner == 1;

    chk("icache_rd_rdy", bus.icache_rd_rdy, win == 0);
    chk("dcache_rd_rdy", bus.dcache_rd_rdy, win == 1);
    chk("arvalid", bus.arvalid, e_arv);
    chk("arid", bus.arid, e_id);
    chk("araddr", bus.araddr, e_addr);
    chk("arlen", bus.arlen, e_len);
    chk("arsize", bus.arsize, 3'b010);
    chk("arburst", bus.arburst, 2'b01);
    chk("rready", bus.rready, e_rr);
    chk("icache_ret_valid", bus.icache_ret_valid, e_rvi);
    chk("dcache_ret_valid", bus.dcache_ret_valid, e_rvd);
    chk("icache_ret_last", bus.icache_ret_last, e_rvi && bus.rlast);
    chk("dcache_ret_last", bus.dcache_ret_last, e_rvd && bus.rlast);
    if (e_rvi) chk("icache_ret_data", bus.icache_ret_data, bus.rdata);
    if (e_rvd) chk("dcache_ret_data", bus.dcache_ret_data, bus.rdata);

    if (bus.arvalid && bus.arready) begin
      chk("single_outstanding", outstanding, 0);
      outstanding++;
      ar_log.push_back({bus.arid, bus.araddr, bus.arlen});
    end
    if (bus.rvalid && bus.rready && bus.rlast && outstanding > 0) outstanding--;
    if (bus.icache_ret_valid) ret_log.push_back({1'b0, bus.icache_ret_last, bus.icache_ret_data});
    if (bus.dcache_ret_valid) ret_log.push_back({1'b1, bus.dcache_ret_last, bus.dcache_ret_data});

    if (!reset) begin
      if (win >= 0) begin
        m_owner = win; m_arp = 1; m_last = (win == 1);
        m_line  = (win == 1) ? bus.dcache_rd_type : bus.icache_rd_type;
        m_addr  = (win == 1) ? bus.dcache_rd_addr : bus.icache_rd_addr;
      end else if (!idle && m_arp) begin
        if (bus.arready) m_arp = 0;
      end else if (!idle && bus.rvalid && bus.rlast) begin
        m_owner = -1;
      end
    end
  end

  // AXI slave: serves each burst for arlen+1 beats; orphaned beats continue after a reset.
  int         beats_left = 0, beat_idx = 0;
  bit         orphan = 0;
  logic [7:0] xfer_no = 0;

  always begin
    bit hs, beat, lst, rs;
    logic [7:0] nl;
    @(negedge clk);
    hs   = bus.arvalid && bus.arready;
    beat = bus.rvalid && (bus.rready || orphan);
    lst  = bus.rlast;
    nl   = bus.arlen;
    rs   = reset;
    @(posedge clk); #1;
    if (beat && beats_left > 0) begin
      beats_left--; beat_idx++;
      if (lst) beats_left = 0;
    end
    if (rs && beats_left > 0) orphan = 1;
    if (hs) begin beats_left = int'(nl) + 1; beat_idx = 0; orphan = 0; xfer_no++; end
    if (beats_left == 0) orphan = 0;
    bus.arready = ($urandom_range(99) < ar_prob);
    bus.rid     = 4'($urandom);
    bus.rresp   = 2'($urandom);
    if (beats_left > 0 && $urandom_range(99) < rv_prob) begin
      bus.rvalid = 1'b1;
      bus.rdata  = {8'hD0, xfer_no, 8'h00, 8'(beat_idx)};
      bus.rlast  = (beats_left == 1) || (early_en != 0 && $urandom_range(19) == 0);
    end else if (stray_en != 0 && beats_left == 0 && $urandom_range(9) == 0) begin
      bus.rvalid = 1'b1;
      bus.rdata  = $urandom;
      bus.rlast  = 1'($urandom);
    end else begin
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rdata  = $urandom;
    end
  end

  initial begin
    reset = 1'b1;
    bus.icache_rd_req = 0; bus.icache_rd_type = 0; bus.icache_rd_addr = 0;
    bus.dcache_rd_req = 0; bus.dcache_rd_type = 0; bus.dcache_rd_addr = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; bus.rdata = 0; bus.rid = 0; bus.rresp = 0;
    #2;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_iret", {bus.icache_ret_valid, bus.icache_ret_last}, 0);
    chk("rst_dret", {bus.dcache_ret_valid, bus.dcache_ret_last}, 0);
    chk("rst_ar", {bus.arid, bus.araddr, bus.arlen}, 0);
    chk("rst_arsize", bus.arsize, 3'b010);
    chk("rst_arburst", bus.arburst, 2'b01);
    tick(3); reset = 1'b0; tick(1);

    // icache line refill, immediate arready
    ret_log.delete(); ar_log.delete();
    bus.icache_rd_type = 1; bus.icache_rd_addr = 32'h1FC0_0014; bus.icache_rd_req = 1; #1;
    chk("t1_irdy", bus.icache_rd_rdy, 1);
    chk("t1_drdy", bus.dcache_rd_rdy, 0);
    tick(1); bus.icache_rd_req = 0;
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'h1FC0_0010);
    chk("t1_arlen", bus.arlen, 3);
    chk("t1_arid", bus.arid, 0);
    wait_rets(4, 30);
    for (int i = 0; i < 4 && i < ret_log.size(); i++) begin
      chk("t1_owner", ret_log[i][33], 0);
      chk("t1_last", ret_log[i][32], i == 3);
      chk("t1_data", {ret_log[i][31:24], ret_log[i][7:0]}, {8'hD0, 8'(i)});
    end
    chk("t1_idle", {bus.arvalid, bus.rready}, 0);

    // dcache single word
    ret_log.delete(); ar_log.delete();
    bus.dcache_rd_type = 0; bus.dcache_rd_addr = 32'h1FAF_F004; bus.dcache_rd_req = 1; #1;
    chk("t2_drdy", bus.dcache_rd_rdy, 1);
    chk("t2_irdy", bus.icache_rd_rdy, 0);
    tick(1); bus.dcache_rd_req = 0;
    wait_rets(1, 30);
    chk("t2_ar", ar_log.size() > 0 ? ar_log[0] : 44'd0, {4'd1, 32'h1FAF_F004, 8'd0});
    chk("t2_ret", ret_log.size() > 0 ? ret_log[0][33:32] : 2'b00, 2'b11);

    // arready stalled for 5 cycles while both keep requesting
    ar_prob = 0; tick(2);
    ret_log.delete();
    bus.icache_rd_type = 1; bus.icache_rd_addr = 32'h0000_1234; bus.icache_rd_req = 1;
    bus.dcache_rd_type = 0; bus.dcache_rd_addr = 32'h5555_0008; bus.dcache_rd_req = 1; #1;
    chk("t3_tie_irdy", bus.icache_rd_rdy, 1);
    chk("t3_tie_drdy", bus.dcache_rd_rdy, 0);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("t3_ar", {bus.arvalid, bus.arid, bus.araddr, bus.arlen}, {1'b1, 4'd0, 32'h0000_1230, 8'd3});
      chk("t3_rdy", {bus.icache_rd_rdy, bus.dcache_rd_rdy}, 0);
      tick(1);
    end
    bus.icache_rd_req = 0; bus.dcache_rd_req = 0; ar_prob = 100;
    wait_rets(4, 40);

    // both requesting from reset: grant order alternates starting with dcache
    reset = 1; tick(2); reset = 0;
    ar_log.delete();
    bus.icache_rd_type = 0; bus.dcache_rd_type = 0;
    bus.icache_rd_addr = 32'h0000_0100; bus.dcache_rd_addr = 32'h0000_0200;
    bus.icache_rd_req = 1; bus.dcache_rd_req = 1;
    wait_ars(4, 100);
    bus.icache_rd_req = 0; bus.dcache_rd_req = 0;
    for (int i = 0; i < 4 && i < ar_log.size(); i++)
      chk("t4_order", ar_log[i][43:40], (i % 2 == 0) ? 4'd1 : 4'd0);
    tick(10);

    // gapped R beats keep order
    rv_prob = 50; ret_log.delete();
    bus.dcache_rd_type = 1; bus.dcache_rd_addr = 32'h8000_0040; bus.dcache_rd_req = 1;
    tick(1); bus.dcache_rd_req = 0;
    wait_rets(4, 100);
    for (int i = 0; i < 4 && i < ret_log.size(); i++)
      chk("t5_order", {ret_log[i][33], ret_log[i][7:0]}, {1'b1, 8'(i)});
    rv_prob = 100; tick(4);

    // reset in the middle of a burst
    ret_log.delete();
    bus.icache_rd_type = 1; bus.icache_rd_addr = 32'h2000_0000; bus.icache_rd_req = 1;
    tick(1); bus.icache_rd_req = 0;
    wait_rets(2, 30);
    reset = 1; #1;
    chk("t6_async", {bus.arvalid, bus.rready, bus.icache_ret_valid, bus.dcache_ret_valid}, 0);
    tick(2); reset = 0; tick(6);
    chk("t6_no_stray", ret_log.size(), 2);
    bus.dcache_rd_type = 0; bus.dcache_rd_addr = 32'h3000_0004; bus.dcache_rd_req = 1; #1;
    chk("t6_drdy", bus.dcache_rd_rdy, 1);
    tick(1); bus.dcache_rd_req = 0;
    wait_rets(3, 30);
    chk("t6_after", ret_log.size() > 2 ? ret_log[2][33:32] : 2'b00, 2'b11);

    // randomized traffic, stray beats, early rlast, occasional resets
    stray_en = 1; early_en = 1; ar_prob = 60; rv_prob = 70;
    for (int c = 0; c < 3000; c++) begin
      bus.icache_rd_req  = ($urandom_range(2) == 0);
      bus.icache_rd_type = 1'($urandom);
      bus.icache_rd_addr = $urandom;
      bus.dcache_rd_req  = ($urandom_range(2) == 0);
      bus.dcache_rd_type = 1'($urandom);
      bus.dcache_rd_addr = $urandom;
      reset = ($urandom_range(399) == 0);
      tick(1);
    end
    reset = 0; bus.icache_rd_req = 0; bus.dcache_rd_req = 0;
    stray_en = 0; early_en = 0; ar_prob = 100; rv_prob = 100;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
